// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: single-miss I-cache line refill initiator toward the imem burst port.
// Critical-word early restart is compiled in only when ICACHE_EARLY_RESTART_EN is defined.
module icache_refill_ctrl #(
    parameter int BLOCK_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           MissValid,
    input  logic [31:0]                    MissAddress,
    output logic                           MissReady,
    output logic                           ReadRequest,
    output logic [31:0]                    ReadAddress,
    input  logic [31:0]                    DataIn,
    input  logic                           DataReady,
    output logic                           FillWe,
    output logic [$clog2(BLOCK_WORDS)-1:0] FillWordIdx,
    output logic [31:0]                    FillData,
    output logic                           FillDone,
    output logic [31:0]                    FillBase,
    output logic                           FillError,
    output logic                           CritValid,
    output logic [31:0]                    CritData
);
    localparam int OFFW = $clog2(BLOCK_WORDS);
    localparam int WDW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [31:0]     LINE_MASK = 32'(BLOCK_WORDS * 4 - 1);
    localparam logic [OFFW-1:0] LAST_IDX  = OFFW'(BLOCK_WORDS - 1);
    localparam logic [WDW-1:0]  WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_readReq;
    logic [31:0]     r_readAddr;
    logic [31:0]     r_fillBase;
    logic [OFFW-1:0] r_count;
    logic [WDW-1:0]  r_wdog;
    logic            r_fillError;
    logic            w_fillWe;
    logic            w_accept;
    logic            w_lastWord;
    logic            w_timeout;
    logic [31:0]     w_blockBase;

    assign w_blockBase = MissAddress & ~LINE_MASK;
    assign w_fillWe    = DataReady && ((r_state == REQ) || (r_state == BURST));
    assign w_accept    = (r_state == IDLE) && MissValid;
    assign w_lastWord  = w_fillWe && (r_count == LAST_IDX);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_state == REQ) && !DataReady
                         && (r_wdog == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        MissReady = 1'b0;
        FillDone  = 1'b0;
        case (r_state)
            IDLE: begin
                MissReady = 1'b1;
                if (MissValid) w_next = REQ;
            end
            REQ: begin
                // BLOCK_WORDS >= 2, so the first word can never also be the last one
                if (w_fillWe)       w_next = BURST;
                else if (w_timeout) w_next = IDLE;
            end
            BURST: begin
                if (w_lastWord) w_next = DONE;
            end
            DONE: begin
                FillDone = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readReq   <= 1'b0;
            r_readAddr  <= '0;
            r_fillBase  <= '0;
            r_count     <= '0;
            r_wdog      <= '0;
            r_fillError <= 1'b0;
        end else begin
            r_fillError <= 1'b0;
            if (w_accept) begin
                r_readReq  <= 1'b1;
                r_readAddr <= w_blockBase;
                r_fillBase <= w_blockBase;
                r_wdog     <= '0;
            end
            if (w_fillWe)   r_count   <= r_count + 1'b1;
            if (w_lastWord) r_readReq <= 1'b0;
            if (r_state == REQ) begin
                if (w_fillWe) begin
                    r_wdog <= '0;
                end else if (w_timeout) begin
                    r_wdog      <= '0;
                    r_readReq   <= 1'b0;
                    r_fillError <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
            if (r_state == DONE) r_count <= '0;
        end
    end

    assign ReadRequest = r_readReq;
    assign ReadAddress = r_readAddr;
    assign FillBase    = r_fillBase;
    assign FillError   = r_fillError;
    assign FillWe      = w_fillWe;
    assign FillData    = DataIn;
    assign FillWordIdx = r_count;

`ifdef ICACHE_EARLY_RESTART_EN
    logic [OFFW-1:0] r_critOff;

    // Word offset of the fetch that missed, forwarded as soon as it streams past
    always_ff @(posedge clk) begin
        if (reset) begin
            r_critOff <= '0;
        end else if (w_accept) begin
            r_critOff <= MissAddress[2 +: OFFW];
        end
    end

    assign CritValid = w_fillWe && (r_count == r_critOff);
    assign CritData  = CritValid ? DataIn : 32'd0;
`else
    assign CritValid = 1'b0;
    assign CritData  = 32'd0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: vector table for the refill sequences plus hand-written reset and
// watchdog sequences; fill writes are matched against a scoreboard of expected words.
module tb_icache_refill_ctrl;
    localparam int TMO = 16;

`ifdef ICACHE_EARLY_RESTART_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MissValid;
    logic [31:0] MissAddress;
    logic        MissReady;
    logic        ReadRequest;
    logic [31:0] ReadAddress;
    logic [31:0] DataIn;
    logic        DataReady;
    logic        FillWe;
    logic [1:0]  FillWordIdx;
    logic [31:0] FillData;
    logic        FillDone;
    logic [31:0] FillBase;
    logic        FillError;
    logic        CritValid;
    logic [31:0] CritData;

    icache_refill_ctrl #(.BLOCK_WORDS(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .MissValid(MissValid), .MissAddress(MissAddress), .MissReady(MissReady),
        .ReadRequest(ReadRequest), .ReadAddress(ReadAddress),
        .DataIn(DataIn), .DataReady(DataReady),
        .FillWe(FillWe), .FillWordIdx(FillWordIdx), .FillData(FillData),
        .FillDone(FillDone), .FillBase(FillBase), .FillError(FillError),
        .CritValid(CritValid), .CritData(CritData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
    } fill_t;

    typedef struct {
        logic        mv;
        logic [31:0] ma;
        logic        dr;
        logic [31:0] din;
        logic        eMr;
        logic        eRr;
        logic [31:0] eRa;
        logic [31:0] eBase;
        logic        eWe;
        logic [1:0]  eIdx;
        logic        eDone;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    fill_t       expQ[$];
    vec_t        vec[$];
    logic [1:0]  critOff = 2'd0;
    logic [31:0] prevRa = 32'd0;
    logic [31:0] prevBase = 32'd0;

    function automatic logic [31:0] word(input logic [31:0] base, input int i);
        return 32'hA500_0000 | base | 32'(i);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every cycle: fill writes must match the scoreboard head, crit outputs follow it
    task automatic sampleFill();
        fill_t       e;
        logic        expCv;
        logic [31:0] expCd;
        expCv = 1'b0;
        expCd = 32'd0;
        if (FillWe === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL fill_unexpected: got write idx=%0d data=%h, expected no write",
                         FillWordIdx, FillData);
            end else begin
                e = expQ.pop_front();
                checkOutput("fill_idx", 32'(FillWordIdx), 32'(e.idx));
                checkOutput("fill_data", FillData, e.data);
                expCv = EARLY && (e.idx == critOff);
                expCd = expCv ? e.data : 32'd0;
            end
        end
        checkOutput("crit_valid", 32'(CritValid), 32'(expCv));
        checkOutput("crit_data", CritData, expCd);
    endtask

    task automatic applyStimulus(input logic rst, input logic mv, input logic [31:0] ma,
                                 input logic dr, input logic [31:0] din);
        @(posedge clk);
        #1;
        reset       = rst;
        MissValid   = mv;
        MissAddress = ma;
        DataReady   = dr;
        DataIn      = din;
        @(negedge clk);
        sampleFill();
    endtask

    task automatic addRow(input logic mv, input logic [31:0] ma, input logic dr,
                          input logic [31:0] din, input logic eMr, input logic eRr,
                          input logic [31:0] eRa, input logic [31:0] eBase, input logic eWe,
                          input logic [1:0] eIdx, input logic eDone);
        vec_t v;
        v.mv = mv; v.ma = ma; v.dr = dr; v.din = din;
        v.eMr = eMr; v.eRr = eRr; v.eRa = eRa; v.eBase = eBase;
        v.eWe = eWe; v.eIdx = eIdx; v.eDone = eDone;
        vec.push_back(v);
    endtask

    // One refill: accept row (DataReady junk ignored in IDLE), REQ waits, 4 words with
    // optional gap after word i, DONE row (DataReady junk ignored). holdMv keeps a miss pending.
    task automatic buildBurst(input logic [31:0] addr, input int waits, input logic [3:0] gaps,
                              input logic holdMv, input logic [31:0] holdAddr);
        logic [31:0] base;
        base = addr & ~32'hF;
        addRow(1'b1, addr, 1'b1, 32'hDEAD_0000, 1'b1, 1'b0, prevRa, prevBase, 1'b0, 2'd0, 1'b0);
        for (int w = 0; w < waits; w++)
            addRow(holdMv, holdAddr, 1'b0, 32'd0, 1'b0, 1'b1, base, base, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            addRow(holdMv, holdAddr, 1'b1, word(base, i), 1'b0, 1'b1, base, base, 1'b1, 2'(i), 1'b0);
            if (gaps[i])
                addRow(holdMv, holdAddr, 1'b0, 32'd0, 1'b0, 1'b1, base, base, 1'b0, 2'(i + 1), 1'b0);
        end
        addRow(holdMv, holdAddr, 1'b1, 32'hBAD0_0000, 1'b0, 1'b0, base, base, 1'b0, 2'd0, 1'b1);
        prevRa   = base;
        prevBase = base;
    endtask

    task automatic addIdleRow();
        addRow(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, prevRa, prevBase, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic runVectors();
        vec_t v;
        for (int i = 0; i < vec.size(); i++) begin
            v = vec[i];
            if (v.mv && v.eMr) critOff = v.ma[3:2];
            if (v.eWe) expQ.push_back('{v.eIdx, v.din});
            applyStimulus(1'b0, v.mv, v.ma, v.dr, v.din);
            checkOutput($sformatf("row%0d_missReady", i), 32'(MissReady), 32'(v.eMr));
            checkOutput($sformatf("row%0d_readReq", i), 32'(ReadRequest), 32'(v.eRr));
            checkOutput($sformatf("row%0d_readAddr", i), ReadAddress, v.eRa);
            checkOutput($sformatf("row%0d_fillBase", i), FillBase, v.eBase);
            checkOutput($sformatf("row%0d_fillWe", i), 32'(FillWe), 32'(v.eWe));
            checkOutput($sformatf("row%0d_fillIdx", i), 32'(FillWordIdx), 32'(v.eIdx));
            checkOutput($sformatf("row%0d_fillDone", i), 32'(FillDone), 32'(v.eDone));
            checkOutput($sformatf("row%0d_fillError", i), 32'(FillError), 32'd0);
        end
        vec.delete();
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected $finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; MissValid = 1'b0; MissAddress = 32'd0; DataReady = 1'b0; DataIn = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_missReady", 32'(MissReady), 32'd1);
        checkOutput("rst_readReq", 32'(ReadRequest), 32'd0);
        checkOutput("rst_readAddr", ReadAddress, 32'd0);
        checkOutput("rst_fillBase", FillBase, 32'd0);
        checkOutput("rst_fillDone", 32'(FillDone), 32'd0);
        checkOutput("rst_fillError", 32'(FillError), 32'd0);
        checkOutput("rst_fillIdx", 32'(FillWordIdx), 32'd0);
        checkOutput("rst_critValid", 32'(CritValid), 32'd0);

        // Back-to-back misses: second held during the first burst, then gaps, then offset 2
        buildBurst(32'h0001_0014, 12, 4'b0000, 1'b1, 32'h0001_0020);
        buildBurst(32'h0001_0020, 2, 4'b0110, 1'b0, 32'd0);
        buildBurst(32'h0001_0028, 2, 4'b0000, 1'b0, 32'd0);
        addIdleRow();
        runVectors();

        // Reset in BURST after two words abandons the line
        applyStimulus(1'b0, 1'b1, 32'h0001_0034, 1'b0, 32'd0);
        critOff = 2'd1;
        checkOutput("rb_accept", 32'(MissReady), 32'd1);
        expQ.push_back('{2'd0, 32'h1111_0000});
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h1111_0000);
        expQ.push_back('{2'd1, 32'h1111_0001});
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h1111_0001);
        checkOutput("rb_readReq_burst", 32'(ReadRequest), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("rb_fillDone_in_reset", 32'(FillDone), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("rb_readReq", 32'(ReadRequest), 32'd0);
        checkOutput("rb_missReady", 32'(MissReady), 32'd1);
        checkOutput("rb_fillBase", FillBase, 32'd0);
        checkOutput("rb_readAddr", ReadAddress, 32'd0);
        checkOutput("rb_fillIdx", 32'(FillWordIdx), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            checkOutput("rb_no_fillDone", 32'(FillDone), 32'd0);
            checkOutput("rb_no_fillError", 32'(FillError), 32'd0);
        end
        prevRa = 32'd0;
        prevBase = 32'd0;
        buildBurst(32'h0001_0058, 1, 4'b0000, 1'b0, 32'd0);
        addIdleRow();
        runVectors();

        // Watchdog: memory never answers
        applyStimulus(1'b0, 1'b1, 32'h0001_004C, 1'b0, 32'd0);
        critOff = 2'd3;
        for (int k = 1; k <= TMO; k++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            checkOutput($sformatf("wd_cycle%0d_fillError", k), 32'(FillError), 32'd0);
            checkOutput($sformatf("wd_cycle%0d_readReq", k), 32'(ReadRequest), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("wd_fillError_pulse", 32'(FillError), 32'd1);
        checkOutput("wd_readReq_drop", 32'(ReadRequest), 32'd0);
        checkOutput("wd_missReady", 32'(MissReady), 32'd1);
        checkOutput("wd_fillBase", FillBase, 32'h0001_0040);
        checkOutput("wd_fillDone", 32'(FillDone), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("wd_fillError_once", 32'(FillError), 32'd0);
        checkOutput("wd_scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
